// File: rtl/pipestage.sv
// pipestage: pipeline stage register with valid/ready handshake.
// Carries an opaque data bundle and a control bundle that is zeroed for bubbles
// (nopin) and on flush. Define PIPESTAGE_SKID_EN to add a two-entry skid buffer
// with a registered readyout; otherwise a single entry with combinational readyout.
module pipestage #(
  parameter int unsigned DATAW = 256,
  parameter int unsigned CTRLW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             validin,
  output logic             readyout,
  input  logic             nopin,
  input  logic [CTRLW-1:0] controlin,
  input  logic [DATAW-1:0] datain,
  output logic             validout,
  input  logic             readyin,
  output logic [CTRLW-1:0] controlout,
  output logic [DATAW-1:0] dataout,
  output logic [1:0]       count
);

  // Encoding equals the number of beats held, so count is the state itself.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CTRLW-1:0] main_ctrl_q;
  logic [DATAW-1:0] main_data_q;
  logic [CTRLW-1:0] ctrl_eff;
  logic             accept, consume;
  logic             load_main_in;

`ifdef PIPESTAGE_SKID_EN
  logic [CTRLW-1:0] skid_ctrl_q;
  logic [DATAW-1:0] skid_data_q;
  logic             load_skid, load_main_skid;
  logic             ready_q, ready_d;

  assign readyout = ready_q;
`else
  assign readyout = readyin || !validout;
`endif

  assign ctrl_eff   = nopin ? '0 : controlin;
  assign accept     = validin && readyout;
  assign consume    = validout && readyin;
  assign validout   = (state_q != StEmpty);
  assign controlout = validout ? main_ctrl_q : '0;
  assign dataout    = main_data_q;
  assign count      = state_q;

  // Next-state and entry load decisions; flush overrides any accept/consume.
  always_comb begin
    state_d      = state_q;
    load_main_in = 1'b0;
`ifdef PIPESTAGE_SKID_EN
    load_skid      = 1'b0;
    load_main_skid = 1'b0;
`endif
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d      = StOne;
            load_main_in = 1'b1;
          end
        end
        StOne: begin
`ifdef PIPESTAGE_SKID_EN
          if (accept && consume) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_d   = StFull;
            load_skid = 1'b1;
          end else if (consume) begin
            state_d = StEmpty;
          end
`else
          // Without a skid entry an accept while valid implies a consume.
          if (accept) begin
            load_main_in = 1'b1;
          end else if (consume) begin
            state_d = StEmpty;
          end
`endif
        end
        StFull: begin
`ifdef PIPESTAGE_SKID_EN
          if (consume) begin
            state_d        = StOne;
            load_main_skid = 1'b1;
          end
`else
          state_d = StEmpty;
`endif
        end
        default: state_d = StEmpty;
      endcase
    end
`ifdef PIPESTAGE_SKID_EN
    ready_d = (state_d != StFull);
`endif
  end

  // State register (and registered upstream ready in the skid build).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
`ifdef PIPESTAGE_SKID_EN
      ready_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
`ifdef PIPESTAGE_SKID_EN
      ready_q <= ready_d;
`endif
    end
  end

  // Main entry payload; holds its value when the entry empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_ctrl_q <= '0;
      main_data_q <= '0;
    end else if (load_main_in) begin
      main_ctrl_q <= ctrl_eff;
      main_data_q <= datain;
`ifdef PIPESTAGE_SKID_EN
    end else if (load_main_skid) begin
      main_ctrl_q <= skid_ctrl_q;
      main_data_q <= skid_data_q;
`endif
    end
  end

`ifdef PIPESTAGE_SKID_EN
  // Skid entry payload, captured when main is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else if (load_skid) begin
      skid_ctrl_q <= ctrl_eff;
      skid_data_q <= datain;
    end
  end
`endif

endmodule
